// File: rtl/timer_sched.sv
// timer_sched: shared-prescaler multi-channel timer with round-robin event port.
// Optional TIMER_SCHED_OVF_EN builds the sticky per-channel overrun flags.
module timer_sched #(
    parameter int P_CLK_PERIOD = 50000000,
    parameter int P_TICK_DIV   = 50000,
    parameter int P_CH_NUM     = 4,
    parameter int P_CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CFG_WE,
    input  logic [1:0]         CFG_CH,
    input  logic [P_CNT_W-1:0] CFG_PERIOD,
    input  logic               CFG_MODE,
    input  logic               CFG_EN,
    output logic               TICK_O,
    output logic [3:0]         CH_LED,
    output logic               EVT_VALID,
    output logic [1:0]         EVT_CH,
    input  logic               EVT_READY,
    output logic [3:0]         EVT_OVF
);
    localparam int PRE_W = $clog2(P_TICK_DIV);

    if (P_TICK_DIV < 2 || P_CH_NUM != 4 || P_CLK_PERIOD < P_TICK_DIV) begin : g_param_check
        $error("timer_sched: unsupported parameter set");
    end

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick, tick_o_q;
    logic [P_CNT_W-1:0] period_q [4];
    logic [P_CNT_W-1:0] period_d [4];
    logic [P_CNT_W-1:0] cnt_q [4];
    logic [P_CNT_W-1:0] cnt_d [4];
    logic [3:0]         mode_q, mode_d, en_q, en_d, led_q, led_d, pend_q, pend_d;
    logic [3:0]         wr, expire, grant;
    logic               evt_valid_q, evt_valid_d, free, gnt_any;
    logic [1:0]         evt_ch_q, evt_ch_d, last_q, last_d, gnt_ch;

    assign tick = pre_q == PRE_W'(P_TICK_DIV - 1);
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);
    assign free = !evt_valid_q || EVT_READY;

    // Descending search so the channel closest after last_q wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch = last_q;
        for (int k = 3; k >= 0; k--) begin
            if (pend_q[last_q + 2'(k) + 2'd1]) begin
                gnt_any = 1'b1;
                gnt_ch = last_q + 2'(k) + 2'd1;
            end
        end
        grant = (free && gnt_any) ? (4'd1 << gnt_ch) : 4'd0;
        evt_valid_d = free ? gnt_any : evt_valid_q;
        evt_ch_d = (free && gnt_any) ? gnt_ch : evt_ch_q;
        last_d = (free && gnt_any) ? gnt_ch : last_q;
    end

    // A write on the same cycle as a tick overrides that tick for its channel.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            wr[c] = CFG_WE && CFG_CH == 2'(c);
            expire[c] = tick && en_q[c] && !wr[c] && cnt_q[c] == period_q[c] - P_CNT_W'(1);
            period_d[c] = wr[c] ? CFG_PERIOD : period_q[c];
            mode_d[c] = wr[c] ? CFG_MODE : mode_q[c];
            en_d[c] = wr[c] ? (CFG_EN && CFG_PERIOD != '0) : (en_q[c] && !(expire[c] && mode_q[c]));
            cnt_d[c] = (wr[c] || expire[c]) ? '0 : (tick && en_q[c]) ? cnt_q[c] + P_CNT_W'(1) : cnt_q[c];
            led_d[c] = led_q[c] ^ expire[c];
            pend_d[c] = !wr[c] && (expire[c] || (pend_q[c] && !grant[c]));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_q <= '0;
            tick_o_q <= 1'b0;
            period_q <= '{default: '0};
            cnt_q <= '{default: '0};
            mode_q <= '0;
            en_q <= '0;
            led_q <= '0;
            pend_q <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q <= '0;
            last_q <= 2'd3;
        end else begin
            pre_q <= pre_d;
            tick_o_q <= tick;
            period_q <= period_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            en_q <= en_d;
            led_q <= led_d;
            pend_q <= pend_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q <= evt_ch_d;
            last_q <= last_d;
        end
    end

    assign TICK_O = tick_o_q;
    assign CH_LED = led_q;
    assign EVT_VALID = evt_valid_q;
    assign EVT_CH = evt_ch_q;

`ifdef TIMER_SCHED_OVF_EN
    logic [3:0] ovf_q, ovf_d;

    // An expiry that finds its previous event still waiting (and not leaving now) is an overrun.
    assign ovf_d = ~wr & (ovf_q | (expire & pend_q & ~grant));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign EVT_OVF = ovf_q;
`else
    assign EVT_OVF = '0;
`endif
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: randomized + directed bench for timer_sched with a countdown reference
// model, an event scoreboard queue and a negedge monitor.
module tb_timer_sched;
    localparam int DIV = 4;

    logic        CLK = 1'b0, RST = 1'b1, CFG_WE = 1'b0, CFG_MODE = 1'b0, CFG_EN = 1'b0, EVT_READY = 1'b1;
    logic [1:0]  CFG_CH = '0;
    logic [15:0] CFG_PERIOD = '0;
    logic        TICK_O, EVT_VALID;
    logic [3:0]  CH_LED, EVT_OVF;
    logic [1:0]  EVT_CH;

    always #5 CLK = ~CLK;

    timer_sched #(.P_CLK_PERIOD(4000000), .P_TICK_DIV(DIV), .P_CH_NUM(4), .P_CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_PERIOD(CFG_PERIOD),
        .CFG_MODE(CFG_MODE), .CFG_EN(CFG_EN), .TICK_O(TICK_O), .CH_LED(CH_LED),
        .EVT_VALID(EVT_VALID), .EVT_CH(EVT_CH), .EVT_READY(EVT_READY), .EVT_OVF(EVT_OVF)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: edges since reset, remaining ticks per channel, pending set.
    int         m_n, m_ch, m_last;
    int         m_rem [4];
    int         m_per [4];
    logic [3:0] m_mode, m_en, m_led, m_pend, m_ovf;
    logic       m_tick, m_valid;
    int         exp_q [$];

    always @(posedge CLK) begin : model
        logic tk, fr, fired;
        int g;
        if (RST) begin
            m_n = 0; m_tick = 0; m_valid = 0; m_ch = 0; m_last = 3;
            m_mode = 0; m_en = 0; m_led = 0; m_pend = 0; m_ovf = 0;
            for (int c = 0; c < 4; c++) begin m_rem[c] = 0; m_per[c] = 0; end
            exp_q.delete();
        end else begin
            m_n++;
            tk = (m_n % DIV) == 0;
            fr = !m_valid || EVT_READY;
            g = -1;
            if (fr) begin
                for (int k = 1; k <= 4; k++)
                    if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
                m_valid = g >= 0;
                if (g >= 0) begin m_ch = g; m_last = g; exp_q.push_back(g); end
            end
            for (int c = 0; c < 4; c++) begin
                if (CFG_WE && int'(CFG_CH) == c) begin
                    m_per[c] = int'(CFG_PERIOD); m_rem[c] = int'(CFG_PERIOD);
                    m_mode[c] = CFG_MODE; m_en[c] = CFG_EN && CFG_PERIOD != 0;
                    m_pend[c] = 0; m_ovf[c] = 0;
                end else begin
                    fired = 0;
                    if (tk && m_en[c]) begin
                        m_rem[c]--;
                        if (m_rem[c] == 0) begin
                            fired = 1;
                            m_rem[c] = m_per[c];
                            m_led[c] = ~m_led[c];
                            if (m_pend[c] && g != c) m_ovf[c] = 1;
                            m_pend[c] = 1;
                            if (m_mode[c]) m_en[c] = 0;
                        end
                    end
                    if (g == c && !fired) m_pend[c] = 0;
                end
            end
            m_tick = tk;
        end
    end

    always @(negedge CLK) begin : monitor
        int e;
        if (!RST) begin
            chk("tick_o", int'(TICK_O), int'(m_tick));
            chk("ch_led", int'(CH_LED), int'(m_led));
            chk("evt_valid", int'(EVT_VALID), int'(m_valid));
            chk("evt_ch", int'(EVT_CH), m_ch);
`ifdef TIMER_SCHED_OVF_EN
            chk("evt_ovf", int'(EVT_OVF), int'(m_ovf));
`else
            chk("evt_ovf", int'(EVT_OVF), 0);
`endif
            if (EVT_VALID && EVT_READY) begin
                if (exp_q.size() == 0) begin
                    chk("evt_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("evt_seq", int'(EVT_CH), e);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int ch, input int per, input logic mode, input logic en);
        CFG_WE = 1; CFG_CH = 2'(ch); CFG_PERIOD = 16'(per); CFG_MODE = mode; CFG_EN = en;
        step(1);
        CFG_WE = 0;
    endtask

    task automatic cfg_on_tick(input int ch, input int per);
        while ((m_n + 1) % DIV != 0) step(1);
        cfg(ch, per, 0, 1);
    endtask

    initial begin
        step(3);
        RST = 0;
        step(20);
        cfg(0, 3, 0, 1);
        step(40);
        cfg(0, 0, 0, 0);
        cfg(1, 2, 1, 1);
        step(60);
        for (int c = 0; c < 4; c++) cfg(c, 1, 0, 1);
        step(30);
        for (int c = 0; c < 4; c++) cfg(c, 0, 0, 0);
        step(5);
        EVT_READY = 0;
        cfg(2, 1, 0, 1);
        step(14);
        EVT_READY = 1;
        step(10);
        cfg(2, 0, 0, 0);
        cfg(3, 0, 0, 1);
        step(20);
        cfg(1, 2, 0, 1);
        step(3);
        cfg_on_tick(1, 2);
        step(20);
        cfg(1, 0, 0, 0);
        cfg(0, 1, 0, 1);
        cfg(3, 2, 0, 1);
        step(9);
        RST = 1;
        step(2);
        RST = 0;
        step(12);
        for (int i = 0; i < 1500; i++) begin
            EVT_READY = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 11) == 0) begin
                CFG_WE = 1; CFG_CH = 2'($urandom_range(0, 3)); CFG_PERIOD = 16'($urandom_range(0, 4));
                CFG_MODE = 1'($urandom_range(0, 1)); CFG_EN = $urandom_range(0, 5) != 0;
            end else begin
                CFG_WE = 0;
            end
            step(1);
        end
        CFG_WE = 0;
        EVT_READY = 1;
        for (int c = 0; c < 4; c++) cfg(c, 0, 0, 0);
        step(20);
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
